word_fetch_ctrl: RTL and testbench

Parametrised successor to the single-word ROM read controller. It turns a Start request plus an index (LFSR count or internal sequencer) into a ROM address, waits a configurable ROM read latency, then presents the word with a Valid/Ready handshake. It adds range folding of out-of-range indices, optional no-immediate-repeat of addresses, a sequential mode and back-to-back fetches. It sits between the LFSR/ROM pair and the downstream word consumer.

---
 rtl/word_fetch_pkg.sv | 24 ++
 rtl/word_addr_sel.sv | 58 +++++
 rtl/word_fetch_ctrl.sv | 130 +++++++++++++
 tb/tb_word_fetch_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_fetch_pkg.sv
// Shared definitions for the word fetch controller: FSM encoding, wait-counter
// sizing and the elaboration-time legality checks on the ROM parameters.
package word_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    // Wait counter holds ROM_LAT-1, so it never needs to exceed 3.
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_ZERO = 2'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 2'd1;

    function automatic bit rom_lat_ok(input int lat);
        return (lat >= 32'sd1) && (lat <= 32'sd4);
    endfunction

    function automatic bit depth_ok(input int depth, input int addr_w);
        return (depth > (32'sd1 << (addr_w - 32'sd1))) && (depth <= (32'sd1 << addr_w));
    endfunction

endpackage

// File: rtl/word_addr_sel.sv
// Next ROM address selection: range fold of random indices, sequential
// increment and the optional no-immediate-repeat adjustment.
module word_addr_sel
    import word_fetch_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter int NO_REPEAT = 1
) (
    input  logic [ADDR_W-1:0] Count,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] idx
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_V   = ADDR_W'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fold_s;
    logic [ADDR_W-1:0] seq_s;
    logic [ADDR_W-1:0] base_s;

    // One subtract suffices because DEPTH exceeds half the index space.
    always_comb begin
        fold_s = Count;
        seq_s  = ADDR_ZERO;
        base_s = ADDR_ZERO;
        idx    = ADDR_ZERO;
        if ({1'b0, Count} >= DEPTH_EXT) begin
            fold_s = Count - DEPTH_V;
        end else begin
            fold_s = Count;
        end
        if (last_addr == LAST_ADDR) begin
            seq_s = ADDR_ZERO;
        end else begin
            seq_s = last_addr + ADDR_ONE;
        end
        if (Mode) begin
            base_s = seq_s;
        end else begin
            base_s = fold_s;
        end
        if ((NO_REPEAT != 32'sd0) && (base_s == last_addr)) begin
            if (base_s == LAST_ADDR) begin
                idx = ADDR_ZERO;
            end else begin
                idx = base_s + ADDR_ONE;
            end
        end else begin
            idx = base_s;
        end
    end

endmodule

// File: rtl/word_fetch_ctrl.sv
// Single-word ROM fetch controller: issues an address on Start, waits the ROM
// read latency, then holds the word under a Valid/Ready handshake.
module word_fetch_ctrl
    import word_fetch_pkg::*;
#(
    parameter int WORD_W    = 64,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter int ROM_LAT   = 1,
    parameter int NO_REPEAT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Mode,
    input  logic [ADDR_W-1:0] Count,
    output logic [ADDR_W-1:0] RomAddr,
    input  logic [WORD_W-1:0] RomData,
    output logic [WORD_W-1:0] WordOut,
    output logic              Valid,
    input  logic              Ready,
    output logic              Busy
);

    if (!rom_lat_ok(ROM_LAT)) begin : g_bad_rom_lat
        $error("word_fetch_ctrl: ROM_LAT must be 1..4");
    end
    if (!depth_ok(DEPTH, ADDR_W)) begin : g_bad_depth
        $error("word_fetch_ctrl: DEPTH must satisfy 2**(ADDR_W-1) < DEPTH <= 2**ADDR_W");
    end

    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(ROM_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fetch_state_e      state_r;
    fetch_state_e      state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] last_addr_r;
    logic [ADDR_W-1:0] idx_s;
    logic              issue_s;
    logic              load_s;
    logic              clear_s;

    word_addr_sel #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .NO_REPEAT (NO_REPEAT)
    ) u_addr_sel (
        .Count     (Count),
        .Mode      (Mode),
        .last_addr (last_addr_r),
        .idx       (idx_s)
    );

    // Next-state decode; Start is only honoured in IDLE or on a HOLD acceptance.
    always_comb begin
        state_s = state_r;
        issue_s = 1'b0;
        load_s  = 1'b0;
        clear_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    issue_s = 1'b1;
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    load_s  = 1'b1;
                    state_s = HOLD;
                end else begin
                    state_s = WAIT;
                end
            end
            HOLD: begin
                if (Ready) begin
                    clear_s = 1'b1;
                    if (Start) begin
                        issue_s = 1'b1;
                        state_s = WAIT;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, address, wait counter and output registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            last_addr_r <= LAST_ADDR;
            RomAddr     <= {ADDR_W{1'b0}};
            WordOut     <= {WORD_W{1'b0}};
            Valid       <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            state_r <= state_s;
            Busy    <= (state_s != IDLE);
            if (issue_s) begin
                RomAddr     <= idx_s;
                last_addr_r <= idx_s;
                cnt_r       <= CNT_LOAD;
            end else if ((state_r == WAIT) && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            if (load_s) begin
                WordOut <= RomData;
                Valid   <= 1'b1;
            end else if (clear_s) begin
                Valid <= 1'b0;
            end else begin
                Valid <= Valid;
            end
        end
    end

endmodule

// File: tb/tb_word_fetch_ctrl.sv
// Directed bench for word_fetch_ctrl: three instances cover DEPTH=32/ROM_LAT=1,
// DEPTH=20 folding, and ROM_LAT=3 without no-repeat.
module tb_word_fetch_ctrl;

    localparam int WORD_W = 64;
    localparam int ADDR_W = 5;

    logic              Clk   = 1'b0;
    logic              Reset = 1'b1;
    logic              Start = 1'b0;
    logic              Mode  = 1'b0;
    logic              Ready = 1'b0;
    logic [ADDR_W-1:0] Count = 5'd0;

    logic [ADDR_W-1:0] addrA, addrB, addrC;
    logic [WORD_W-1:0] dataA, dataB, dataC;
    logic [WORD_W-1:0] woA, woB, woC;
    logic              validA, validB, validC;
    logic              busyA, busyB, busyC;

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    function automatic logic [WORD_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return {16'hDEAD, 11'd0, a, 16'hBEEF, 11'd0, ~a};
    endfunction

    assign dataA = rom_word(addrA);
    assign dataB = rom_word(addrB);
    assign dataC = rom_word(addrC);

    word_fetch_ctrl #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(32), .ROM_LAT(1), .NO_REPEAT(1)) dutA (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Count(Count),
        .RomAddr(addrA), .RomData(dataA), .WordOut(woA), .Valid(validA), .Ready(Ready), .Busy(busyA)
    );

    word_fetch_ctrl #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(20), .ROM_LAT(1), .NO_REPEAT(1)) dutB (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Count(Count),
        .RomAddr(addrB), .RomData(dataB), .WordOut(woB), .Valid(validB), .Ready(Ready), .Busy(busyB)
    );

    word_fetch_ctrl #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .DEPTH(32), .ROM_LAT(3), .NO_REPEAT(0)) dutC (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode), .Count(Count),
        .RomAddr(addrC), .RomData(dataC), .WordOut(woC), .Valid(validC), .Ready(Ready), .Busy(busyC)
    );

    task automatic do_reset();
        Reset = 1'b0;
        Start = 1'b0;
        Mode  = 1'b0;
        Ready = 1'b0;
        Count = 5'd0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    // One ROM_LAT=1 fetch from IDLE: Start for one edge, word lands next edge, accept.
    task automatic fetch1(input logic [ADDR_W-1:0] cnt, input logic md);
        Start = 1'b1;
        Count = cnt;
        Mode  = md;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Ready = 1'b1;
        @(negedge Clk);
        Ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #1;
        n_vec++;
        if (addrA !== 5'd0 || woA !== 64'd0 || validA !== 1'b0 || busyA !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got addr=%0d word=%h valid=%b busy=%b, want 0/0/0/0",
                     addrA, woA, validA, busyA);
        end
        do_reset();
        n_vec++;
        if (validA !== 1'b0 || busyA !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_idle: got valid=%b busy=%b, want 0/0", validA, busyA);
        end
    endtask

    task automatic test_random_fetch();
        do_reset();
        Start = 1'b1;
        Count = 5'd5;
        Mode  = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        n_vec++;
        if (addrA !== 5'd5 || validA !== 1'b0 || busyA !== 1'b1) begin
            n_err++;
            $display("FAIL rand_issue: got addr=%0d valid=%b busy=%b, want 5/0/1", addrA, validA, busyA);
        end
        @(negedge Clk);
        n_vec++;
        if (validA !== 1'b1 || woA !== rom_word(5'd5) || busyA !== 1'b1) begin
            n_err++;
            $display("FAIL rand_word: got valid=%b word=%h busy=%b, want 1/%h/1",
                     validA, woA, busyA, rom_word(5'd5));
        end
        Ready = 1'b1;
        @(negedge Clk);
        Ready = 1'b0;
        n_vec++;
        if (validA !== 1'b0 || busyA !== 1'b0 || woA !== rom_word(5'd5) || addrA !== 5'd5) begin
            n_err++;
            $display("FAIL rand_accept: got valid=%b busy=%b word=%h addr=%0d, want 0/0/%h/5",
                     validA, busyA, woA, addrA, rom_word(5'd5));
        end
    endtask

    task automatic test_fold();
        do_reset();
        fetch1(5'd25, 1'b0);
        n_vec++;
        if (addrB !== 5'd5) begin
            n_err++;
            $display("FAIL fold_25: got addr=%0d want 5", addrB);
        end
        fetch1(5'd19, 1'b0);
        n_vec++;
        if (addrB !== 5'd19) begin
            n_err++;
            $display("FAIL fold_19: got addr=%0d want 19", addrB);
        end
        fetch1(5'd20, 1'b0);
        n_vec++;
        if (addrB !== 5'd0 || woB !== rom_word(5'd0)) begin
            n_err++;
            $display("FAIL fold_20: got addr=%0d word=%h want 0/%h", addrB, woB, rom_word(5'd0));
        end
    endtask

    task automatic test_no_repeat();
        do_reset();
        fetch1(5'd7, 1'b0);
        n_vec++;
        if (addrA !== 5'd7) begin
            n_err++;
            $display("FAIL norep_first: got addr=%0d want 7", addrA);
        end
        fetch1(5'd7, 1'b0);
        n_vec++;
        if (addrA !== 5'd8) begin
            n_err++;
            $display("FAIL norep_bump: got addr=%0d want 8", addrA);
        end
        fetch1(5'd31, 1'b0);
        n_vec++;
        if (addrA !== 5'd31) begin
            n_err++;
            $display("FAIL norep_31: got addr=%0d want 31", addrA);
        end
        fetch1(5'd31, 1'b0);
        n_vec++;
        if (addrA !== 5'd0 || woA !== rom_word(5'd0)) begin
            n_err++;
            $display("FAIL norep_wrap: got addr=%0d word=%h want 0/%h", addrA, woA, rom_word(5'd0));
        end
    endtask

    task automatic test_sequential();
        logic [ADDR_W-1:0] exp_addr;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fetch1(5'd13, 1'b1);
            exp_addr = 5'(i);
            n_vec++;
            if (addrA !== exp_addr) begin
                n_err++;
                $display("FAIL seq_step%0d: got addr=%0d want %0d", i, addrA, exp_addr);
            end
        end
        n_vec++;
        if (addrB !== 5'd2) begin
            n_err++;
            $display("FAIL seq_depth20: got addr=%0d want 2", addrB);
        end
        fetch1(5'd31, 1'b0);
        fetch1(5'd4, 1'b1);
        n_vec++;
        if (addrA !== 5'd0) begin
            n_err++;
            $display("FAIL seq_wrap: got addr=%0d want 0", addrA);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        Start = 1'b1;
        Count = 5'd3;
        Mode  = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Count = 5'd10;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (validA !== 1'b1 || woA !== rom_word(5'd3) || addrA !== 5'd3) begin
                n_err++;
                $display("FAIL hold_stall%0d: got valid=%b word=%h addr=%0d want 1/%h/3",
                         i, validA, woA, addrA, rom_word(5'd3));
            end
            @(negedge Clk);
        end
        Ready = 1'b1;
        @(negedge Clk);
        Ready = 1'b0;
        Start = 1'b0;
        n_vec++;
        if (addrA !== 5'd10 || validA !== 1'b0 || busyA !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_issue: got addr=%0d valid=%b busy=%b want 10/0/1", addrA, validA, busyA);
        end
        @(negedge Clk);
        n_vec++;
        if (validA !== 1'b1 || woA !== rom_word(5'd10)) begin
            n_err++;
            $display("FAIL b2b_word: got valid=%b word=%h want 1/%h", validA, woA, rom_word(5'd10));
        end
        Ready = 1'b1;
        @(negedge Clk);
        Ready = 1'b0;
        n_vec++;
        if (validA !== 1'b0 || busyA !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_idle: got valid=%b busy=%b want 0/0", validA, busyA);
        end
    endtask

    task automatic test_lat3_abort();
        logic [1:0] exp_valid;
        do_reset();
        Start = 1'b1;
        Count = 5'd7;
        Mode  = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        n_vec++;
        if (addrC !== 5'd7 || validC !== 1'b0 || busyC !== 1'b1) begin
            n_err++;
            $display("FAIL lat3_issue: got addr=%0d valid=%b busy=%b want 7/0/1", addrC, validC, busyC);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge Clk);
            exp_valid = (i == 3) ? 2'd1 : 2'd0;
            n_vec++;
            if (validC !== exp_valid[0]) begin
                n_err++;
                $display("FAIL lat3_valid_k%0d: got valid=%b want %b", i, validC, exp_valid[0]);
            end
        end
        n_vec++;
        if (woC !== rom_word(5'd7)) begin
            n_err++;
            $display("FAIL lat3_word: got word=%h want %h", woC, rom_word(5'd7));
        end
        Ready = 1'b1;
        @(negedge Clk);
        Ready = 1'b0;
        Start = 1'b1;
        Count = 5'd7;
        @(negedge Clk);
        Start = 1'b0;
        n_vec++;
        if (addrC !== 5'd7 || busyC !== 1'b1) begin
            n_err++;
            $display("FAIL lat3_repeat_ok: got addr=%0d busy=%b want 7/1", addrC, busyC);
        end
        repeat (3) @(negedge Clk);
        Ready = 1'b1;
        @(negedge Clk);
        Ready = 1'b0;
        Start = 1'b1;
        Count = 5'd9;
        @(negedge Clk);
        Start = 1'b0;
        n_vec++;
        if (addrC !== 5'd9 || busyC !== 1'b1) begin
            n_err++;
            $display("FAIL abort_issue: got addr=%0d busy=%b want 9/1", addrC, busyC);
        end
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        n_vec++;
        if (addrC !== 5'd0 || woC !== 64'd0 || validC !== 1'b0 || busyC !== 1'b0) begin
            n_err++;
            $display("FAIL abort_async: got addr=%0d word=%h valid=%b busy=%b want 0/0/0/0",
                     addrC, woC, validC, busyC);
        end
        @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            n_vec++;
            if (validC !== 1'b0 || busyC !== 1'b0) begin
                n_err++;
                $display("FAIL abort_quiet%0d: got valid=%b busy=%b want 0/0", i, validC, busyC);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_random_fetch();
        test_fold();
        test_no_repeat();
        test_sequential();
        test_back_to_back();
        test_lat3_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
